// File: rtl/thresholding_loader.sv
// Streams ascending per-channel thresholds into the thresholding core's write port.
// Optional strict-ascending order check: define THRESHOLDING_LOADER_ORDER_CHECK_EN.
module thresholding_loader #(
  parameter int N = 2,
  parameter int M = 8,
  parameter int C = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic [M-1:0]            s_tdata,
  output logic                    twe,
  output logic [$clog2(C)+N-1:0]  twa,
  output logic [M-1:0]            twd,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [1:0]              dbg_state_o
);

  localparam int AW = $clog2(C) + N;
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam logic [N-1:0]  IDX_LAST = N'(2**N - 2);
  localparam logic [CW-1:0] CH_LAST  = CW'(C - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [N-1:0]    idx_q, idx_d;
  logic            s_tready_q, s_tready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            twe_q, twe_d;
  logic [AW-1:0]   twa_q, twa_d;
  logic [M-1:0]    twd_q, twd_d;

  logic            hs;
  logic            viol;
  logic            last_beat;
  logic [AW-1:0]   addr;

  // Handshake: a beat transfers on a rising edge where s_tvalid && s_tready are
  // both high; a start pulse in the same cycle wins and the beat is not taken.
  assign hs        = s_tvalid && s_tready_q && !start;
  assign last_beat = (idx_q == IDX_LAST) && (ch_q == CH_LAST);

  if (C > 1) begin : g_addr_ch
    assign addr = {ch_q, idx_q};
  end else begin : g_addr_noch
    assign addr = idx_q;
  end

`ifdef THRESHOLDING_LOADER_ORDER_CHECK_EN
  logic signed [M-1:0] prev_q, prev_d;

  // Index 0 opens a channel, so it has no predecessor to compare against.
  assign viol = hs && (idx_q != '0) && !($signed(s_tdata) > prev_q);

  always_comb begin
    prev_d = prev_q;
    if (start) begin
      prev_d = '0;
    end else if (hs && !viol) begin
      prev_d = (idx_q == IDX_LAST) ? '0 : $signed(s_tdata);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end
`else
  assign viol = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (viol) begin
            state_d = S_ERR;
          end else if (hs && last_beat) begin
            state_d = S_DONE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Channel-major beat counters; they hold on gaps and on a rejected beat.
  always_comb begin
    ch_d  = ch_q;
    idx_d = idx_q;
    if (start) begin
      ch_d  = '0;
      idx_d = '0;
    end else if (hs && !viol) begin
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
        ch_d  = (ch_q == CH_LAST) ? '0 : ch_q + CW'(1);
      end else begin
        idx_d = idx_q + N'(1);
      end
    end
  end

  // Output logic: status flags are decoded from the upcoming state so they
  // change together with the state register.
  always_comb begin
    s_tready_d = (state_d == S_LOAD);
    busy_d     = (state_d == S_LOAD);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
    twe_d      = hs && !viol;
    twa_d      = twa_q;
    twd_d      = twd_q;
    if (hs && !viol) begin
      twa_d = addr;
      twd_d = s_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      idx_q      <= '0;
      s_tready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      twe_q      <= 1'b0;
      twa_q      <= '0;
      twd_q      <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      idx_q      <= idx_d;
      s_tready_q <= s_tready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      twe_q      <= twe_d;
      twa_q      <= twa_d;
      twd_q      <= twd_d;
    end
  end

  assign s_tready    = s_tready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign twe         = twe_q;
  assign twa         = twa_q;
  assign twd         = twd_q;
  assign dbg_state_o = state_q;

`ifdef THRESHOLDING_LOADER_ORDER_CHECK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_thresholding_loader.sv
// Bench for thresholding_loader: beat-level driver, cycle-exact write monitor and
// an index-arithmetic reference model of the expected write sequence.
module tb_thresholding_loader;

  localparam int N  = 2;
  localparam int M  = 8;
  localparam int C  = 2;
  localparam int L  = 2**N - 1;
  localparam int AW = $clog2(C) + N;
`ifdef THRESHOLDING_LOADER_ORDER_CHECK_EN
  localparam bit ORDER_EN = 1'b1;
`else
  localparam bit ORDER_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic s_tvalid = 1'b0;
  logic [M-1:0] s_tdata = '0;
  logic s_tready, twe, busy, done, err;
  logic [AW-1:0] twa;
  logic [M-1:0] twd;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  thresholding_loader #(.N(N), .M(M), .C(C)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .twe(twe), .twa(twa), .twd(twd),
    .busy(busy), .done(done), .err(err), .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_write_cyc = -10;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [AW+M-1:0] exp_q[$];
  int k = 0;
  logic signed [M-1:0] prev = '0;
  bit m_err = 1'b0;

  function automatic logic [AW-1:0] write_addr(input int n);
    return AW'((n / L) * (2**N) + (n % L));
  endfunction

  function automatic bit model_accept(input logic [M-1:0] d);
    bit bad;
    bad = ORDER_EN && (k % L != 0) && !($signed(d) > prev);
    if (bad) begin
      m_err = 1'b1;
      return 1'b0;
    end
    exp_q.push_back({write_addr(k), d});
    prev = d;
    k++;
    return 1'b1;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic exp_twe;
    logic [AW+M-1:0] e;
    exp_twe = (last_write_cyc == cyc - 1);
    checks++;
    if (twe !== exp_twe) begin
      errors++;
      $display("FAIL twe_timing cyc=%0d got %b want %b", cyc, twe, exp_twe);
    end
    if (twe === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL twe_extra cyc=%0d got twa=%0d twd=%0d want no write", cyc, twa, twd);
      end else begin
        e = exp_q.pop_front();
        if ({twa, twd} !== e) begin
          errors++;
          $display("FAIL write_data cyc=%0d got twa=%0d twd=%0d want twa=%0d twd=%0d",
                   cyc, twa, twd, e[AW+M-1:M], e[M-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks (phase: 1 time unit after posedge) ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    m_err = 1'b0;
    prev = '0;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_beat(input logic [M-1:0] d);
    bit got;
    got = 1'b0;
    s_tvalid = 1'b1;
    s_tdata = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (s_tready && !start) begin
        got = 1'b1;
        @(posedge clk); #1;
        if (model_accept(d)) last_write_cyc = cyc - 1;
      end
    end
    s_tvalid = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL beat_accept got no handshake in 20 cycles want handshake for %0d", $signed(d));
      @(posedge clk); #1;
    end
  endtask

  task automatic check_done(input string tag);
    @(negedge clk); #1;
    checks++;
    if ({done, err, busy, s_tready} !== 4'b1000) begin
      errors++;
      $display("FAIL %s_status got done=%b err=%b busy=%b rdy=%b want 1 0 0 0",
               tag, done, err, busy, s_tready);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_writes got %0d missing writes want 0", tag, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic check_loading(input string tag);
    @(negedge clk);
    checks++;
    if ({s_tready, busy, done, err} !== 4'b1100) begin
      errors++;
      $display("FAIL %s_load got rdy=%b busy=%b done=%b err=%b want 1 1 0 0",
               tag, s_tready, busy, done, err);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  logic [M-1:0] vec [6];

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({s_tready, twe, twa, twd, busy, done, err, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_values got rdy=%b twe=%b twa=%0d twd=%0d busy=%b done=%b err=%b st=%0d want all 0",
               s_tready, twe, twa, twd, busy, done, err, dbg_state);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    s_tvalid = 1'b1;
    idle(0);
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (s_tready !== 1'b0) begin
        errors++;
        $display("FAIL idle_ready got %b want 0", s_tready);
      end
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic test_stream();
    pulse_start();
    check_loading("stream");
    for (int i = 0; i < 6; i++) send_beat(vec[i]);
    check_done("stream");
  endtask

  task automatic test_stalls();
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      idle(1);
      send_beat(vec[i]);
    end
    check_done("stalls");
  endtask

  task automatic test_restart();
    pulse_start();
    for (int i = 0; i < 4; i++) send_beat(vec[i]);
    s_tvalid = 1'b1;
    s_tdata = 8'd99;
    pulse_start();
    s_tvalid = 1'b0;
    check_loading("restart");
    for (int i = 0; i < 6; i++) send_beat(vec[i]);
    check_done("restart");
  endtask

  task automatic test_order_check();
    pulse_start();
    send_beat(8'd3);
    send_beat(8'd3);
    if (ORDER_EN) begin
      s_tvalid = 1'b1;
      repeat (3) begin
        @(negedge clk);
        checks++;
        if ({err, s_tready, done, busy} !== 4'b1000) begin
          errors++;
          $display("FAIL order_err got err=%b rdy=%b done=%b busy=%b want 1 0 0 0",
                   err, s_tready, done, busy);
        end
        @(posedge clk); #1;
      end
      s_tvalid = 1'b0;
      pulse_start();
      check_loading("order_clear");
    end else begin
      send_beat(8'd1);
      @(negedge clk); #1;
      checks++;
      if ({err, busy, exp_q.size() == 0} !== 3'b011) begin
        errors++;
        $display("FAIL order_off got err=%b busy=%b pending=%0d want 0 1 0",
                 err, busy, exp_q.size());
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rst_mid_load();
    pulse_start();
    send_beat(vec[0]);
    send_beat(vec[1]);
    rst = 1'b1;
    s_tvalid = 1'b1;
    s_tdata = vec[2];
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({s_tready, twe, twa, twd, busy, done, err, dbg_state} !== '0) begin
      errors++;
      $display("FAIL rst_abort got rdy=%b twe=%b twa=%0d twd=%0d busy=%b done=%b err=%b st=%0d want all 0",
               s_tready, twe, twa, twd, busy, done, err, dbg_state);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_pending got %0d writes outstanding want 0", exp_q.size());
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (s_tready !== 1'b0) begin
        errors++;
        $display("FAIL rst_idle_ready got %b want 0", s_tready);
      end
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int v;
      pulse_start();
      for (int ch = 0; ch < C; ch++) begin
        v = int'($urandom_range(0, 80)) - 100;
        for (int i = 0; i < L; i++) begin
          idle(int'($urandom_range(0, 2)));
          send_beat(M'(v));
          v += int'($urandom_range(1, 30));
        end
      end
      check_done("random");
      idle(2);
      @(negedge clk);
      checks++;
      if (done !== 1'b1) begin
        errors++;
        $display("FAIL done_hold got %b want 1", done);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vec[0] = 8'hFB; vec[1] = 8'd0; vec[2] = 8'd7;
    vec[3] = 8'd1;  vec[4] = 8'd2; vec[5] = 8'd3;
    test_reset();
    test_stream();
    test_stalls();
    test_restart();
    test_order_check();
    test_rst_mid_load();
    test_random();
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no end of test want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/thresholding_loader.md
# thresholding_loader

Configuration writer for the binary-search thresholding pipeline. Accepts per-channel threshold sets as an AXI-Stream-style sequence of ascending values and drives the pipeline's threshold write port (`twe`/`twa`/`twd`), one write per accepted beat. Sits between the host/DMA threshold stream and the thresholding core. Reports load completion and ordering violations.

## Interface
Parameters:
- `N`, none: output precision of the target thresholding core; each channel takes 2^N-1 thresholds.
- `M`, none: threshold precision; values are signed.
- `C`, none: number of channels.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  single-cycle pulse; begins or restarts a full load.
- `s_tvalid`  in  1  threshold beat valid.
- `s_tready`  out  1  beat accepted when `s_tvalid && s_tready`.
- `s_tdata`  in  M  signed threshold value.
- `twe`  out  1  threshold write enable to the core.
- `twa`  out  $clog2(C)+N  write address: {channel, N-bit index}.
- `twd`  out  M  write data.
- `busy`  out  1  high while in LOAD.
- `done`  out  1  high in DONE; all C*(2^N-1) thresholds written.
- `err`  out  1  high in ERR; ordering violation detected.

## Operation
- Beat order: channel-major. Channel 0 indices 0..2^N-2, then channel 1, … up to channel C-1.
- Address: `twa` = {channel, index}. Index 2^N-1 is never generated; it selects no stage in the core.
- Within a channel, index i is the i-th threshold in ascending order. The core's stage-select decoding places each value in its binary-search stage, so the loader performs no reordering.
- FSM states:
  - IDLE: `s_tready`=0. `start` moves to LOAD.
  - LOAD: `s_tready`=1.
    - Each handshake issues one write and advances the index.
    - At index 2^N-2 the index wraps to 0 and the channel increments.
    - A handshake at channel C-1, index 2^N-2 moves to DONE.
  - DONE: `s_tready`=0, `done`=1. `start` moves to LOAD.
  - ERR: `s_tready`=0, `err`=1. `start` moves to LOAD.
- `start` in any state (including mid-LOAD) resets channel and index to 0, clears `done`/`err` and enters LOAD. A beat presented in the same cycle as `start` is not accepted.
- Channel counter is $clog2(C) bits and counts 0..C-1 only; for C==1 the channel field is absent and `twa` is N bits.
- Reset values: state IDLE, `s_tready`=0, `twe`=0, `twa`=0, `twd`=0, `busy`=0, `done`=0, `err`=0, counters 0.
- `rst` mid-load aborts immediately. A registered write pending in that cycle is dropped: `twe`=0 the next cycle.

## Timing
- Outputs are registered.
- A handshake in cycle t produces `twe`=1 with matching `twa`/`twd` in cycle t+1, for exactly one cycle.
- `s_tready` is a registered function of state: it rises the cycle after `start`, and falls the cycle after the last beat or an error beat.
- Full load with no stalls: C*(2^N-1) cycles of `s_tready`. `done` rises one cycle after the last handshake, together with the final `twe`.
- `s_tvalid` gaps: no write, counters hold.
- `busy` = (state == LOAD).

## Configuration
- `THRESHOLDING_LOADER_ORDER_CHECK_EN` defined:
  - Within a channel, each beat at index > 0 must be strictly greater (signed compare, M bits) than the previous beat of that channel.
  - On a violation, that beat's write is suppressed (`twe` stays 0) and the FSM enters ERR in the next cycle.
  - The previous-value register resets at each channel start.
- Macro undefined: no comparator or previous-value register; ERR is unreachable and `err` is tied to 0.

## Test plan
- N=2, M=8, C=2: `start`, then stream -5,0,7,1,2,3 with no stalls. Expect `twa` = 0,1,2,4,5,6 and `twd` equal to the inputs, one `twe` per cycle; `done`=1 one cycle after the 6th handshake; `err`=0.
- Same data with `s_tvalid` low every other cycle: same write sequence, no extra `twe`, `done` after the 6th accepted beat.
- `start` pulse after 4 beats: counters return to 0; the next beat writes `twa`=0; the load completes after 6 further beats.
- Order check enabled, ch0 = 3,3: first beat writes `twa`=0; second beat gives no `twe`; `err`=1, `s_tready`=0 thereafter; a following `start` clears `err`.
- Order check disabled, ch0 = 3,3,1: all three writes issued (`twa` 0,1,2); `err` stays 0.
- `rst` asserted in the cycle after the 2nd handshake: the pending `twe` is dropped, all outputs return to reset values, state IDLE, `s_tready`=0 until `start`.
